// File: rtl/axis_cube_pipe_if.sv
// AXI-Stream bundle for axis_cube_pipe; tuser exists only when AXIS_CUBE_OVF_EN is defined.
interface axis_cube_pipe_if #(parameter int unsigned DATA_W = 64);
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tlast;
   logic              tready;
`ifdef AXIS_CUBE_OVF_EN
   logic              tuser;

   modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
   modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
`else
   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
`endif
endinterface

// File: rtl/axis_cube_pipe.sv
// Two-stage pipelined AXI-Stream cuber (x^3 mod 2^DATA_W) with bubble collapse.
// Optional overflow flag on m.tuser when AXIS_CUBE_OVF_EN is defined.
module axis_cube_pipe #(
   parameter int unsigned DATA_W = 64
) (
   input logic              clk,
   input logic              rst,
   axis_cube_pipe_if.slave  s,
   axis_cube_pipe_if.master m
);
`ifdef AXIS_CUBE_OVF_EN
   localparam int unsigned SQ_W = 2 * DATA_W;
   localparam int unsigned PR_W = 2 * DATA_W;
`else
   localparam int unsigned SQ_W = DATA_W;
   localparam int unsigned PR_W = DATA_W;
`endif

   logic              v1;
   logic              l1;
   logic [DATA_W-1:0] x1;
   logic [SQ_W-1:0]   sq1;

   logic              vld_q;
   logic              last_q;
   logic [DATA_W-1:0] data_q;

   logic              en1_c;
   logic              en2_c;
   logic [SQ_W-1:0]   sq_c;
   logic [PR_W-1:0]   prod_c;

   // Each stage advances when it is empty or the stage after it is moving.
   assign en2_c    = !vld_q || m.tready;
   assign en1_c    = !v1 || en2_c;
   assign s.tready = en1_c;

   assign sq_c   = SQ_W'(s.tdata) * SQ_W'(s.tdata);
   assign prod_c = PR_W'(sq1[DATA_W-1:0]) * PR_W'(x1);

   // Stage 1: capture operand and its square.
   always_ff @(posedge clk) begin
      if (!rst) begin
         v1  <= 1'b0;
         l1  <= 1'b0;
         x1  <= '0;
         sq1 <= '0;
      end else if (en1_c) begin
         v1 <= s.tvalid;
         if (s.tvalid) begin
            x1  <= s.tdata;
            sq1 <= sq_c;
            l1  <= s.tlast;
         end
      end
   end

   // Stage 2: output register; tlast is forced low whenever the slot goes empty.
   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_q  <= 1'b0;
         last_q <= 1'b0;
         data_q <= '0;
      end else if (en2_c) begin
         vld_q  <= v1;
         last_q <= v1 && l1;
         if (v1) begin
            data_q <= prod_c[DATA_W-1:0];
         end
      end
   end

   assign m.tvalid = vld_q;
   assign m.tlast  = last_q;
   assign m.tdata  = data_q;

`ifdef AXIS_CUBE_OVF_EN
   logic user_q;
   logic ovf_c;

   // True cube overflows if either the square or the final product spills past DATA_W.
   assign ovf_c = (|sq1[SQ_W-1:DATA_W]) || (|prod_c[PR_W-1:DATA_W]);

   always_ff @(posedge clk) begin
      if (!rst) begin
         user_q <= 1'b0;
      end else if (en2_c && v1) begin
         user_q <= ovf_c;
      end
   end

   assign m.tuser = user_q;
`endif
endmodule

// File: tb/tb_axis_cube_pipe.sv
// Self-checking bench for axis_cube_pipe: directed steps plus randomized traffic
// against a queue-based reference that cubes operands with wide arithmetic.
module tb_axis_cube_pipe;
   localparam int unsigned DATA_W = 64;

   logic clk = 1'b0;
   logic rst;

   axis_cube_pipe_if #(.DATA_W(DATA_W)) s_if ();
   axis_cube_pipe_if #(.DATA_W(DATA_W)) m_if ();

   axis_cube_pipe #(.DATA_W(DATA_W)) dut (
      .clk (clk),
      .rst (rst),
      .s   (s_if),
      .m   (m_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DATA_W-1:0] d;
      logic              l;
      logic              u;
   } exp_t;

   exp_t              exp_q[$];
   int                errs   = 0;
   int                checks = 0;
   int                n_out  = 0;
   bit                stall_prev = 1'b0;
   logic [DATA_W-1:0] held_data;
   logic              held_last;
   logic              held_user;

   function automatic exp_t model(input logic [DATA_W-1:0] x, input logic l);
      logic [191:0] b;
      exp_t e;
      b   = 192'(x);
      b   = b * b * b;
      e.d = b[DATA_W-1:0];
      e.l = l;
      e.u = |b[191:DATA_W];
      return e;
   endfunction

   function automatic logic user_now();
`ifdef AXIS_CUBE_OVF_EN
      return m_if.tuser;
`else
      return 1'b0;
`endif
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      checks++;
      assert (obs === expv) else begin
         errs++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic logic [DATA_W-1:0] rand_word();
      case ($urandom_range(0, 3))
         0:       return DATA_W'($urandom_range(0, 300));
         1:       return DATA_W'($urandom_range(2000000, 3000000));
         default: return {$urandom, $urandom};
      endcase
   endfunction

   // One clock: observe at negedge (scoreboard + hold rules), then step past posedge.
   task automatic cycle(output bit hs);
      exp_t e;
      hs = 1'b0;
      @(negedge clk);
      if (rst == 1'b0) begin
         exp_q.delete();
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("hold_valid", 128'(m_if.tvalid), 128'(1));
            check("hold_data", 128'(m_if.tdata), 128'(held_data));
            check("hold_last", 128'(m_if.tlast), 128'(held_last));
`ifdef AXIS_CUBE_OVF_EN
            check("hold_user", 128'(m_if.tuser), 128'(held_user));
`endif
         end
         if (!m_if.tvalid) check("last_idle", 128'(m_if.tlast), 128'(0));
         if (m_if.tvalid && m_if.tready) begin
            if (exp_q.size() == 0) begin
               check("extra_out", 128'(exp_q.size()), 128'(1));
            end else begin
               e = exp_q.pop_front();
               check("data", 128'(m_if.tdata), 128'(e.d));
               check("last", 128'(m_if.tlast), 128'(e.l));
`ifdef AXIS_CUBE_OVF_EN
               check("user", 128'(m_if.tuser), 128'(e.u));
`endif
            end
            n_out++;
         end
         if (s_if.tvalid && s_if.tready) begin
            exp_q.push_back(model(s_if.tdata, s_if.tlast));
            hs = 1'b1;
         end
         stall_prev = m_if.tvalid && !m_if.tready;
         held_data  = m_if.tdata;
         held_last  = m_if.tlast;
         held_user  = user_now();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_expect(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] expd,
                              input logic expu);
      bit hs;
      int n;
      s_if.tvalid = 1'b1;
      s_if.tdata  = x;
      s_if.tlast  = 1'b0;
      cycle(hs);
      check("single_accept", 128'(hs), 128'(1));
      s_if.tvalid = 1'b0;
      n = 0;
      while (!m_if.tvalid && n < 8) begin
         cycle(hs);
         n++;
      end
      check("single_latency", 128'(n), 128'(1));
      check("single_data", 128'(m_if.tdata), 128'(expd));
`ifdef AXIS_CUBE_OVF_EN
      check("single_user", 128'(m_if.tuser), 128'(expu));
`else
      if (expu === 1'bx) check("single_user_arg", 128'(expu), 128'(0));
`endif
      cycle(hs);
   endtask

   initial begin
      bit hs;
      int n0;
      int sent;

      rst         = 1'b0;
      s_if.tvalid = 1'b1;
      s_if.tdata  = 64'd7;
      s_if.tlast  = 1'b0;
`ifdef AXIS_CUBE_OVF_EN
      s_if.tuser  = 1'b0;
`endif
      m_if.tready = 1'b1;

      // Reset held with a valid input present.
      for (int i = 0; i < 3; i++) begin
         cycle(hs);
         check("rst_tvalid", 128'(m_if.tvalid), 128'(0));
         check("rst_tdata", 128'(m_if.tdata), 128'(0));
         check("rst_tready", 128'(s_if.tready), 128'(1));
      end
      rst = 1'b1;
      cycle(hs);
      check("release_tvalid", 128'(m_if.tvalid), 128'(0));
      s_if.tvalid = 1'b0;
      for (int i = 0; i < 3; i++) cycle(hs);
      check("release_drained", 128'(exp_q.size()), 128'(0));

      // Single word x=3 with explicit 2-clock latency and 1-clock valid pulse.
      s_if.tvalid = 1'b1;
      s_if.tdata  = 64'd3;
      cycle(hs);
      check("x3_accept", 128'(hs), 128'(1));
      s_if.tvalid = 1'b0;
      check("x3_lat_early", 128'(m_if.tvalid), 128'(0));
      cycle(hs);
      check("x3_valid", 128'(m_if.tvalid), 128'(1));
      check("x3_data", 128'(m_if.tdata), 128'(27));
      cycle(hs);
      check("x3_pulse_end", 128'(m_if.tvalid), 128'(0));

      // Back-to-back stream 0..99 with TLAST on the final word.
      n0 = n_out;
      for (int i = 0; i < 100; i++) begin
         s_if.tvalid = 1'b1;
         s_if.tdata  = DATA_W'(i);
         s_if.tlast  = (i == 99);
         cycle(hs);
         check("stream_tready", 128'(hs), 128'(1));
      end
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      cycle(hs);
      cycle(hs);
      check("stream_count", 128'(n_out - n0), 128'(100));
      check("stream_empty", 128'(exp_q.size()), 128'(0));

      // Stall the sink for 10 clocks mid-stream.
      s_if.tvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         s_if.tdata = DATA_W'(1000 + i);
         cycle(hs);
      end
      m_if.tready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         s_if.tdata = DATA_W'(2000 + i);
         cycle(hs);
      end
      check("bp_tready_low", 128'(s_if.tready), 128'(0));
      check("bp_tvalid", 128'(m_if.tvalid), 128'(1));
      check("bp_in_flight", 128'(exp_q.size()), 128'(2));
      s_if.tvalid = 1'b0;
      m_if.tready = 1'b1;
      for (int i = 0; i < 4; i++) cycle(hs);
      check("bp_drained", 128'(exp_q.size()), 128'(0));

      // Random source valid and 50% sink ready over 1000 words.
      sent = 0;
      for (int c = 0; c < 8000 && sent < 1000; c++) begin
         if (!s_if.tvalid && $urandom_range(0, 3) != 0) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = rand_word();
            s_if.tlast  = ($urandom_range(0, 7) == 0);
         end
         m_if.tready = 1'($urandom_range(0, 1));
         cycle(hs);
         if (hs) begin
            sent++;
            s_if.tvalid = 1'b0;
            s_if.tlast  = 1'b0;
         end
      end
      check("rand_sent", 128'(sent), 128'(1000));
      s_if.tvalid = 1'b0;
      m_if.tready = 1'b1;
      for (int i = 0; i < 4; i++) cycle(hs);
      check("rand_drained", 128'(exp_q.size()), 128'(0));

      // Overflow boundary values.
      send_expect(64'd2642245, 64'd18446724184312856125, 1'b0);
      send_expect(64'd2642246, 64'(model(64'd2642246, 1'b0).d), 1'b1);
      send_expect(64'd4194304, 64'd0, 1'b1);

      // Reset pulse with two words in flight under backpressure.
      m_if.tready = 1'b0;
      s_if.tvalid = 1'b1;
      s_if.tdata  = 64'd11;
      cycle(hs);
      s_if.tdata  = 64'd12;
      cycle(hs);
      s_if.tvalid = 1'b0;
      check("mid_full", 128'(s_if.tready), 128'(0));
      rst = 1'b0;
      cycle(hs);
      rst = 1'b1;
      check("mid_rst_tvalid", 128'(m_if.tvalid), 128'(0));
      check("mid_rst_tready", 128'(s_if.tready), 128'(1));
      check("mid_rst_tdata", 128'(m_if.tdata), 128'(0));
      m_if.tready = 1'b1;
      cycle(hs);
      check("mid_dropped", 128'(m_if.tvalid), 128'(0));
      send_expect(64'd5, 64'd125, 1'b0);
      check("final_empty", 128'(exp_q.size()), 128'(0));

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
